writeback_stage: RTL and testbench
==================================

# writeback_stage

Final pipeline stage. Consumes the 60-bit bundle registered at the end of the memory stage and selects the write-back value: memory read data when memToReg=1, ALU result/address otherwise. Drives the register-file write port through a one-entry holding register with a ready/stall handshake. Also provides a forwarding tap for execute, a retire counter and halt detection.

## Interface
- DATA_W, 24, write-back data width
- REG_AW, 4, register address width
- BUNDLE_W, 60, input bundle width
- CNT_W, 16, retire counter width
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  pipeline advance (same enable that drives the upstream bundle register)
- bundleIn  input  BUNDLE_W  {opType[59:58], opCode[57:54], memToReg[53], regWrite[52], Rc[51:48], memData[47:24], aluData[23:0]}
- bundleValid  input  1  bundleIn holds a real instruction (0 = bubble)
- rfReady  input  1  register file accepts a write this cycle
- stallOut  output  1  stage cannot accept; upstream must hold
- rfWe  output  1  register-file write enable
- rfAddr  output  REG_AW  write address
- rfData  output  DATA_W  write data
- fwdValid  output  1  fwdRc/fwdData hold a not-yet-written result
- fwdRc  output  REG_AW  forwarded destination
- fwdData  output  DATA_W  forwarded value
- retireCount  output  CNT_W  instructions retired, wraps
- haltOut  output  1  halt instruction retired

## Operation
- States: IDLE (no entry held), HOLD (one entry held), HALTED.
- accept = en & bundleValid & ~stallOut. On accept, the holding register captures Rc, regWrite, a halt flag and selData = memToReg ? memData : aluData.
- stallOut = HALTED | (HOLD & regWrite_h & ~rfReady). This is combinational.
- HOLD, regWrite_h=1: rfWe=1, rfAddr=Rc_h, rfData=selData_h. The entry retires on the edge where rfReady=1.
- HOLD, regWrite_h=0: rfWe=0. The entry retires unconditionally on the next edge.
- Retire with accept on the same edge: remain in HOLD with the new entry. Retire without accept: go to IDLE. Retire of a halt entry: go to HALTED and ignore any same-cycle accept.
- Halt entry: opType=2'b11 and opCode=4'hF. HALTED sets haltOut=1, stallOut=1 and rfWe=0. Only reset leaves HALTED.
- IDLE with accept: go to HOLD.
- retireCount increments by 1 on every retire and wraps from 2^CNT_W-1 to 0.
- fwdValid = HOLD & regWrite_h. fwdRc = Rc_h and fwdData = selData_h; both are 0 when fwdValid=0.
- en=0 blocks capture only. A held entry still drains when rfReady=1.
- bundleValid=0 is a bubble: nothing is captured, no retire occurs, the counter does not change.
- Rc=0 is written like any other register; no suppression in this stage.

## Timing
- Reset (rst=0, asynchronous): state IDLE, holding register cleared. rfWe, rfAddr, rfData, fwdValid, fwdRc, fwdData, retireCount, haltOut and stallOut are all 0.
- Latency: a bundle accepted at edge N presents rfWe=1 during cycle N+1. With rfReady=1 it retires at edge N+1.
- Throughput: 1 instruction per cycle when rfReady is held high.
- Backpressure: rfReady=0 while HOLD & regWrite_h raises stallOut in the same cycle. The entry and its outputs stay stable until rfReady=1.
- Reset during HOLD drops the pending write. rfWe is 0 from reset assertion onward, and the dropped write is never issued.
- All outputs except stallOut come directly from registers.

## Structure
- Package pipeline_pkg holds:
  - bundle field offsets and widths for the 60-bit layout
  - HALT_OPTYPE (2'b11) and HALT_OPCODE (4'hF)
  - wb_state_t enum {IDLE, HOLD, HALTED}
  - wb_bundle_t packed struct matching the bundle layout
- Sub-module wb_bundle_unpack: combinational unpacker with the memToReg mux; outputs Rc, regWrite, selData and isHalt.
- writeback_stage: state register, holding register, counter and handshake logic.

## Test plan
- Reset, then bundleValid=1 with memToReg=1, regWrite=1, Rc=5, memData=24'hABCDEF, rfReady=1 -> next cycle rfWe=1, rfAddr=5, rfData=24'hABCDEF, fwdValid=1; following edge retireCount=1.
- Back-to-back bundles, memToReg=0, aluData=1,2,3 to Rc=1,2,3, rfReady=1 -> one write per cycle, in order; retireCount=3; stallOut stays 0.
- Bundle held while rfReady=0 for 4 cycles -> stallOut=1 and rfWe/rfAddr/rfData stable for all 4 cycles; the write completes on the first rfReady=1 edge; the next bundle is accepted on that same edge.
- regWrite=0 bundle -> rfWe never asserts, fwdValid=0, retireCount increments after 1 cycle.
- Halt bundle (opType=2'b11, opCode=4'hF) followed by a valid bundle -> haltOut=1 after retire, stallOut=1, the following bundle is never written, retireCount increments exactly once for the halt.
- rst pulled low while an entry is held with rfReady=0 -> all outputs 0 immediately; after release, rfWe stays 0 until a new bundle is accepted.
- retireCount preset near 16'hFFFF by streaming no-write bundles -> wraps to 0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the write-back stage:
// bundle layout, halt encoding and stage state.
package pipeline_pkg;

    localparam int DATA_W   = 24;
    localparam int REG_AW   = 4;
    localparam int BUNDLE_W = 60;
    localparam int CNT_W    = 16;

    localparam int ALU_LSB  = 0;
    localparam int ALU_W    = 24;
    localparam int MEM_LSB  = 24;
    localparam int MEM_W    = 24;
    localparam int RC_LSB   = 48;
    localparam int RC_W     = 4;
    localparam int RW_BIT   = 52;
    localparam int M2R_BIT  = 53;
    localparam int OPC_LSB  = 54;
    localparam int OPC_W    = 4;
    localparam int OPT_LSB  = 58;
    localparam int OPT_W    = 2;

    localparam logic [1:0] HALT_OPTYPE = 2'b11;
    localparam logic [3:0] HALT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [OPT_W-1:0]  op_type;
        logic [OPC_W-1:0]  op_code;
        logic              mem_to_reg;
        logic              reg_write;
        logic [RC_W-1:0]   rc;
        logic [MEM_W-1:0]  mem_data;
        logic [ALU_W-1:0]  alu_data;
    } wb_bundle_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Write-back stage port bundle: upstream bundle handshake,
// register-file write port, forwarding tap and status.
interface writeback_stage_if;
    import pipeline_pkg::*;

    logic                en;
    logic [BUNDLE_W-1:0] bundleIn;
    logic                bundleValid;
    logic                rfReady;
    logic                stallOut;
    logic                rfWe;
    logic [REG_AW-1:0]   rfAddr;
    logic [DATA_W-1:0]   rfData;
    logic                fwdValid;
    logic [REG_AW-1:0]   fwdRc;
    logic [DATA_W-1:0]   fwdData;
    logic [CNT_W-1:0]    retireCount;
    logic                haltOut;

    modport master (
        output en, bundleIn, bundleValid, rfReady,
        input  stallOut, rfWe, rfAddr, rfData,
        input  fwdValid, fwdRc, fwdData,
        input  retireCount, haltOut
    );

    modport slave (
        input  en, bundleIn, bundleValid, rfReady,
        output stallOut, rfWe, rfAddr, rfData,
        output fwdValid, fwdRc, fwdData,
        output retireCount, haltOut
    );

endinterface

// File: rtl/wb_bundle_unpack.sv
// Splits the memory-stage bundle and picks the
// write-back value (memory data vs ALU result).
module wb_bundle_unpack
    import pipeline_pkg::*;
(
    input  logic [BUNDLE_W-1:0] bundle,
    output logic [REG_AW-1:0]   rc,
    output logic                reg_write,
    output logic [DATA_W-1:0]   sel_data,
    output logic                is_halt
);

    wb_bundle_t b;

    always_comb begin
        b         = wb_bundle_t'(bundle);
        rc        = b.rc;
        reg_write = b.reg_write;
        sel_data  = b.mem_to_reg ? b.mem_data : b.alu_data;
        is_halt   = (b.op_type == HALT_OPTYPE) &&
                    (b.op_code == HALT_OPCODE);
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: one-entry holding register in front
// of the register-file write port, with forwarding and halt.
module writeback_stage
    import pipeline_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  bus
);

    wb_state_t          state_q, state_d;
    logic               we_q, we_d;
    logic [REG_AW-1:0]  rc_q, rc_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               halt_q, halt_d;
    logic               halt_out_q, halt_out_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [REG_AW-1:0]  up_rc;
    logic               up_wr;
    logic [DATA_W-1:0]  up_data;
    logic               up_halt;

    logic               stall;
    logic               accept;
    logic               retire;

    wb_bundle_unpack u_unpack (
        .bundle    (bus.bundleIn),
        .rc        (up_rc),
        .reg_write (up_wr),
        .sel_data  (up_data),
        .is_halt   (up_halt)
    );

    // we_q is only ever set while in HOLD, so it doubles as
    // the "held entry writes" qualifier everywhere below.
    always_comb begin
        stall  = (state_q == HALTED) ||
                 (state_q == HOLD && we_q && !bus.rfReady);
        accept = bus.en && bus.bundleValid && !stall;
        retire = (state_q == HOLD) && (!we_q || bus.rfReady);
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        rc_d       = rc_q;
        data_d     = data_q;
        halt_d     = halt_q;
        halt_out_d = halt_out_q;
        cnt_d      = cnt_q;
        if (retire) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        unique case (state_q)
            IDLE, HOLD: begin
                if (retire && halt_q) begin
                    state_d    = HALTED;
                    halt_out_d = 1'b1;
                end
                if (retire || state_q == IDLE) begin
                    if (accept && !(retire && halt_q)) begin
                        state_d = HOLD;
                        we_d    = up_wr;
                        rc_d    = up_wr ? up_rc : '0;
                        data_d  = up_wr ? up_data : '0;
                        halt_d  = up_halt;
                    end else begin
                        if (!(retire && halt_q)) begin
                            state_d = IDLE;
                        end
                        we_d   = 1'b0;
                        rc_d   = '0;
                        data_d = '0;
                        halt_d = 1'b0;
                    end
                end
            end
            HALTED: begin
                we_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                we_d    = 1'b0;
                rc_d    = '0;
                data_d  = '0;
                halt_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            rc_q       <= '0;
            data_q     <= '0;
            halt_q     <= 1'b0;
            halt_out_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            rc_q       <= rc_d;
            data_q     <= data_d;
            halt_q     <= halt_d;
            halt_out_q <= halt_out_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.stallOut    = stall;
    assign bus.rfWe        = we_q;
    assign bus.rfAddr      = rc_q;
    assign bus.rfData      = data_q;
    assign bus.fwdValid    = we_q;
    assign bus.fwdRc       = rc_q;
    assign bus.fwdData     = data_q;
    assign bus.retireCount = cnt_q;
    assign bus.haltOut     = halt_out_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
module tb_writeback_stage;
    import pipeline_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    writeback_stage_if bus ();

    writeback_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BUNDLE_W-1:0] mk(
        input logic [1:0]  opt,
        input logic [3:0]  opc,
        input logic        m2r,
        input logic        rw,
        input logic [3:0]  rc,
        input logic [23:0] mem,
        input logic [23:0] alu);
        return {opt, opc, m2r, rw, rc, mem, alu};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, ".rfWe"},    32'(bus.rfWe), 32'd0);
        chk({tag, ".rfAddr"},  32'(bus.rfAddr), 32'd0);
        chk({tag, ".rfData"},  32'(bus.rfData), 32'd0);
        chk({tag, ".fwdValid"},32'(bus.fwdValid), 32'd0);
        chk({tag, ".fwdRc"},   32'(bus.fwdRc), 32'd0);
        chk({tag, ".fwdData"}, 32'(bus.fwdData), 32'd0);
        chk({tag, ".count"},   32'(bus.retireCount), 32'd0);
        chk({tag, ".halt"},    32'(bus.haltOut), 32'd0);
        chk({tag, ".stall"},   32'(bus.stallOut), 32'd0);
    endtask

    initial begin
        errors          = 0;
        checks          = 0;
        rst             = 1'b1;
        bus.en          = 1'b0;
        bus.bundleIn    = '0;
        bus.bundleValid = 1'b0;
        bus.rfReady     = 1'b0;
        #3 rst = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b1;
        bus.en = 1'b1;
        bus.rfReady = 1'b1;

        // memToReg=1 write
        bus.bundleIn = mk(2'b00, 4'h1, 1'b1, 1'b1, 4'd5,
                          24'hABCDEF, 24'h123456);
        bus.bundleValid = 1'b1;
        tick();
        bus.bundleValid = 1'b0;
        chk("t1.rfWe",   32'(bus.rfWe), 32'd1);
        chk("t1.rfAddr", 32'(bus.rfAddr), 32'd5);
        chk("t1.rfData", 32'(bus.rfData), 32'hABCDEF);
        chk("t1.fwdV",   32'(bus.fwdValid), 32'd1);
        chk("t1.fwdD",   32'(bus.fwdData), 32'hABCDEF);
        chk("t1.cnt0",   32'(bus.retireCount), 32'd0);
        tick();
        chk("t1.cnt1",   32'(bus.retireCount), 32'd1);
        chk("t1.weoff",  32'(bus.rfWe), 32'd0);
        chk("t1.fwdoff", 32'(bus.fwdValid), 32'd0);

        // back-to-back ALU writes
        for (int i = 1; i <= 3; i++) begin
            bus.bundleIn = mk(2'b00, 4'h2, 1'b0, 1'b1, 4'(i),
                              24'hFFFFFF, 24'(i));
            bus.bundleValid = 1'b1;
            tick();
            chk("t2.rfWe",   32'(bus.rfWe), 32'd1);
            chk("t2.rfAddr", 32'(bus.rfAddr), 32'(i));
            chk("t2.rfData", 32'(bus.rfData), 32'(i));
            chk("t2.stall",  32'(bus.stallOut), 32'd0);
            chk("t2.cnt",    32'(bus.retireCount), 32'(i));
        end
        bus.bundleValid = 1'b0;
        tick();
        chk("t2.cnt4", 32'(bus.retireCount), 32'd4);

        // backpressure for 4 cycles
        bus.bundleIn = mk(2'b00, 4'h3, 1'b0, 1'b1, 4'd7,
                          24'h0, 24'h77);
        bus.bundleValid = 1'b1;
        tick();
        bus.rfReady = 1'b0;
        bus.bundleIn = mk(2'b00, 4'h3, 1'b0, 1'b1, 4'd8,
                          24'h0, 24'h88);
        #1;
        chk("t3.stall0", 32'(bus.stallOut), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3.stall", 32'(bus.stallOut), 32'd1);
            chk("t3.rfWe",  32'(bus.rfWe), 32'd1);
            chk("t3.addr",  32'(bus.rfAddr), 32'd7);
            chk("t3.data",  32'(bus.rfData), 32'h77);
            chk("t3.cnt",   32'(bus.retireCount), 32'd4);
        end
        bus.rfReady = 1'b1;
        #1;
        chk("t3.unstall", 32'(bus.stallOut), 32'd0);
        tick();
        bus.bundleValid = 1'b0;
        chk("t3.addr8", 32'(bus.rfAddr), 32'd8);
        chk("t3.data8", 32'(bus.rfData), 32'h88);
        chk("t3.cnt5",  32'(bus.retireCount), 32'd5);
        tick();
        chk("t3.cnt6",  32'(bus.retireCount), 32'd6);

        // regWrite=0 drains even without rfReady
        bus.rfReady = 1'b0;
        bus.bundleIn = mk(2'b00, 4'h4, 1'b0, 1'b0, 4'd9,
                          24'h0, 24'h99);
        bus.bundleValid = 1'b1;
        tick();
        bus.bundleValid = 1'b0;
        chk("t4.rfWe",  32'(bus.rfWe), 32'd0);
        chk("t4.fwdV",  32'(bus.fwdValid), 32'd0);
        chk("t4.fwdRc", 32'(bus.fwdRc), 32'd0);
        chk("t4.stall", 32'(bus.stallOut), 32'd0);
        tick();
        chk("t4.cnt7",  32'(bus.retireCount), 32'd7);
        bus.rfReady = 1'b1;

        // halt followed by a valid bundle
        bus.bundleIn = mk(2'b11, 4'hF, 1'b0, 1'b0, 4'd0,
                          24'h0, 24'h0);
        bus.bundleValid = 1'b1;
        tick();
        bus.bundleIn = mk(2'b00, 4'h5, 1'b0, 1'b1, 4'd3,
                          24'h0, 24'h33);
        tick();
        chk("t5.halt",  32'(bus.haltOut), 32'd1);
        chk("t5.stall", 32'(bus.stallOut), 32'd1);
        chk("t5.rfWe",  32'(bus.rfWe), 32'd0);
        chk("t5.cnt8",  32'(bus.retireCount), 32'd8);
        tick();
        tick();
        chk("t5.rfWe2", 32'(bus.rfWe), 32'd0);
        chk("t5.cnt8b", 32'(bus.retireCount), 32'd8);
        chk("t5.halt2", 32'(bus.haltOut), 32'd1);
        bus.bundleValid = 1'b0;

        // reset leaves HALTED; reset during a stalled write
        rst = 1'b0;
        #1;
        chk_all_zero("t6a");
        rst = 1'b1;
        bus.rfReady = 1'b0;
        bus.bundleIn = mk(2'b00, 4'h6, 1'b0, 1'b1, 4'd4,
                          24'h0, 24'h44);
        bus.bundleValid = 1'b1;
        tick();
        bus.bundleValid = 1'b0;
        chk("t6.rfWe", 32'(bus.rfWe), 32'd1);
        chk("t6.stall", 32'(bus.stallOut), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_all_zero("t6b");
        #2 rst = 1'b1;
        bus.rfReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6.noWe", 32'(bus.rfWe), 32'd0);
        end

        // counter wrap via streamed no-write bundles
        bus.bundleIn = mk(2'b00, 4'h7, 1'b0, 1'b0, 4'd1,
                          24'h0, 24'h0);
        bus.bundleValid = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        bus.bundleValid = 1'b0;
        tick();
        chk("t7.ffff", 32'(bus.retireCount), 32'hFFFF);
        bus.bundleValid = 1'b1;
        tick();
        bus.bundleValid = 1'b0;
        tick();
        chk("t7.wrap", 32'(bus.retireCount), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
